// File: rtl/regfile_pkg.sv
// Shared register-file widths, the writeback request record and the grant-source encoding.
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_MEM,
        GNT_FIFO,
        GNT_ALU
    } grant_e;

endpackage

// File: rtl/regwrite_arbiter_wb_fifo.sv
// DEPTH-entry FIFO of writeback requests; pushes when full and pops when empty are ignored.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  wb_req_t       i_data,
    input  logic          i_pop,
    output wb_req_t       o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    wb_req_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: memory returns win, ALU results queue in a FIFO,
// and a per-register scoreboard tracks loads that are still outstanding.
module regwrite_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [REG_DATA_W-1:0] mem_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic [REG_DATA_W-1:0] write_data,
    output logic [REG_ADDR_W-1:0] write_address,
    output logic                  is_write,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_DATA_W-1:0] r_write_data;
    logic [REG_ADDR_W-1:0] r_write_address;
    logic                  r_is_write;
    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_overflow;

    wb_req_t               w_head;
    wb_req_t               w_grant_req;
    grant_e                w_grant;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_alu_ready;
    logic                  w_alu_take;
    logic                  w_push;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_busy_next;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_data ('{addr: alu_addr, data: alu_data}),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_count(w_count),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    assign w_alu_ready = (w_count < CW'(DEPTH));
    assign w_alu_take  = alu_valid && w_alu_ready;

    always_comb begin
        w_grant     = GNT_NONE;
        w_grant_req = '0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        if (mem_valid) begin
            w_grant     = GNT_MEM;
            w_grant_req = '{addr: mem_addr, data: mem_data};
            w_push      = w_alu_take;
        end else if (!w_empty) begin
            w_grant     = GNT_FIFO;
            w_grant_req = w_head;
            w_pop       = 1'b1;
            w_push      = w_alu_take;
        end else if (alu_valid) begin
            w_grant     = GNT_ALU;
            w_grant_req = '{addr: alu_addr, data: alu_data};
        end
    end

    // Set is applied after clear so a same-cycle issue to the returning register stays busy.
    always_comb begin
        w_busy_next = r_busy;
        if (mem_valid) begin
            w_busy_next[mem_addr] = 1'b0;
        end
        if (issue_valid) begin
            w_busy_next[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_data    <= '0;
            r_write_address <= '0;
            r_is_write      <= 1'b0;
            r_busy          <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_is_write <= (w_grant != GNT_NONE);
            if (w_grant != GNT_NONE) begin
                r_write_address <= w_grant_req.addr;
                r_write_data    <= w_grant_req.data;
            end
            if (alu_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            r_busy <= w_busy_next;
        end
    end

    assign alu_ready     = w_alu_ready;
    assign write_data    = r_write_data;
    assign write_address = r_write_address;
    assign is_write      = r_is_write;
    assign busy          = r_busy;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: queue-based reference model, per-cycle compare, directed scenarios, random traffic.
module tb_regwrite_arbiter;
    import regfile_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_addr = '0;
    logic [15:0] write_data;
    logic [2:0]  write_address;
    logic        is_write;
    logic [7:0]  busy;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    regwrite_arbiter #(
        .DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .write_data   (write_data),
        .write_address(write_address),
        .is_write     (is_write),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending ALU results are simply a queue of (addr,data) pairs.
    wb_req_t     q[$];
    logic [15:0] m_wd = '0;
    logic [2:0]  m_wa = '0;
    logic        m_we = 1'b0;
    logic [7:0]  m_busy = '0;
    logic        m_ovf = 1'b0;
    logic        m_ready = 1'b1;

    always @(posedge clk) begin
        bit room;
        if (rst) begin
            q.delete();
            m_wd = '0; m_wa = '0; m_we = 1'b0; m_busy = '0; m_ovf = 1'b0;
        end else begin
            room = (q.size() < DEPTH);
            if (alu_valid && !room) m_ovf = 1'b1;
            if (mem_valid) begin
                m_we = 1'b1; m_wa = mem_addr; m_wd = mem_data;
                if (alu_valid && room) q.push_back('{addr: alu_addr, data: alu_data});
            end else if (q.size() > 0) begin
                wb_req_t h;
                h = q.pop_front();
                m_we = 1'b1; m_wa = h.addr; m_wd = h.data;
                if (alu_valid && room) q.push_back('{addr: alu_addr, data: alu_data});
            end else if (alu_valid) begin
                m_we = 1'b1; m_wa = alu_addr; m_wd = alu_data;
            end else begin
                m_we = 1'b0;
            end
            if (mem_valid) m_busy[mem_addr] = 1'b0;
            if (issue_valid) m_busy[issue_addr] = 1'b1;
        end
        m_ready = (q.size() < DEPTH);
    end

    always @(posedge clk) begin
        #1;
        check("cmp_write_data", write_data, m_wd);
        check("cmp_write_address", write_address, m_wa);
        check("cmp_is_write", is_write, m_we);
        check("cmp_busy", busy, m_busy);
        check("cmp_overflow", overflow, m_ovf);
        check("cmp_alu_ready", alu_ready, m_ready);
    end

    task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                         input logic mv, input logic [2:0] ma, input logic [15:0] md,
                         input logic iv, input logic [2:0] ia);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        issue_valid = iv; issue_addr = ia;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("idle_is_write", is_write, 0);
        check("idle_busy", busy, 0);
        check("idle_alu_ready", alu_ready, 1);
        check("idle_overflow", overflow, 0);

        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0);
        tick();
        check("bypass_addr", write_address, 3);
        check("bypass_data", write_data, 16'h1234);
        check("bypass_we", is_write, 1);
        check("bypass_ready", alu_ready, 1);
        idle();
        tick();
        check("bypass_done", is_write, 0);

        drive(1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd0);
        tick();
        check("coll_mem_data", write_data, 16'hAAAA);
        check("coll_mem_addr", write_address, 2);
        idle();
        tick();
        check("coll_alu_data", write_data, 16'h5555);
        check("coll_alu_we", is_write, 1);
        tick();
        check("coll_done_we", is_write, 0);
        check("coll_done_ready", alu_ready, 1);

        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 3'd4, 16'(i + 1), 1'b1, 3'd1, 16'hF000 + 16'(i), 1'b0, 3'd0);
            tick();
            if (i == 0) check("bp_ready_1", alu_ready, 1);
            if (i == 1) check("bp_ready_full", alu_ready, 0);
            if (i == 2) check("bp_overflow", overflow, 1);
            if (i == 3) check("bp_mem_data", write_data, 16'hF003);
        end
        check("bp_model_q", q.size(), 2);
        idle();
        tick();
        check("bp_first", write_data, 16'h0001);
        check("bp_first_addr", write_address, 4);
        tick();
        check("bp_second", write_data, 16'h0002);
        tick();
        check("bp_drained", is_write, 0);
        check("bp_sticky", overflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_ovf", overflow, 0);

        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
        tick();
        check("sb_set", busy, 8'h20);
        idle();
        tick();
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0);
        tick();
        check("sb_clear", busy, 8'h00);
        check("sb_clear_we", is_write, 1);
        drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h0BAD, 1'b1, 3'd5);
        tick();
        check("sb_set_wins", busy, 8'h20);
        idle();
        tick();

        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd6, 16'hC000 + 16'(i), 1'b1, 3'd0, 16'h0101, 1'b0, 3'd0);
            tick();
        end
        check("md_full", alu_ready, 0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("md_rst_we", is_write, 0);
        check("md_rst_ready", alu_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("md_never_written", is_write, 0);
        end

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 9) < 3, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0, 3'($urandom));
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
